// File: rtl/mist_video_pkg.sv
// Shared types and constants for the MiST video configuration scheduler.
// MIST_VIDEO_LINECNT_EN (in the top) enables the per-frame line counter.
package mist_video_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        BLANK
    } sched_state_t;

    // Config word field positions: {rotate, blend, no_csync, ypbpr, sd_disable, scanlines, spare}
    localparam int unsigned CFG_ROTATE_LSB     = 7;
    localparam int unsigned CFG_ROTATE_W       = 2;
    localparam int unsigned CFG_BLEND_BIT      = 6;
    localparam int unsigned CFG_NO_CSYNC_BIT   = 5;
    localparam int unsigned CFG_YPBPR_BIT      = 4;
    localparam int unsigned CFG_SD_DISABLE_BIT = 3;
    localparam int unsigned CFG_SCANLINES_LSB  = 1;
    localparam int unsigned CFG_SCANLINES_W    = 2;
    localparam int unsigned CFG_SPARE_BIT      = 0;

    localparam int unsigned LINE_CNT_W = 10;

endpackage

// File: rtl/mist_sync_edge.sv
// Registers a sync input and emits a one-cycle pulse on its leading edge.
module mist_sync_edge #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync,
    output logic lead
);

    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= ACTIVE_LOW;
        end else begin
            sync_q <= sync;
        end
    end

    assign lead = ACTIVE_LOW ? (sync_q & ~sync) : (~sync_q & sync);

endmodule

// File: rtl/mist_video_cfg_sched.sv
// Applies video config changes only at VSync leading edges, then blanks for a few frames.
// Define MIST_VIDEO_LINECNT_EN to enable the lines_per_frame / frame_stable monitor.
module mist_video_cfg_sched
    import mist_video_pkg::*;
#(
    parameter int unsigned         CFG_W         = 9,
    parameter logic [CFG_W-1:0]    RESET_CFG     = '0,
    parameter int unsigned         BLANK_FRAMES  = 2,
    parameter int unsigned         TIMEOUT_CYC   = 2_000_000,
    parameter int unsigned         TO_W          = 21,
    parameter bit                  VS_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CFG_W-1:0]      cfg_data,
    input  logic                  HSync,
    input  logic                  VSync,
    output logic [CFG_W-1:0]      cfg_applied,
    output logic                  blank,
    output logic                  busy,
    output logic                  timeout_flag,
    output logic [LINE_CNT_W-1:0] lines_per_frame,
    output logic                  frame_stable
);

    localparam logic [TO_W-1:0] TO_LOAD    = TO_W'(TIMEOUT_CYC);
    localparam logic [1:0]      FRAME_LOAD = 2'(BLANK_FRAMES);

    sched_state_t      state;
    logic [CFG_W-1:0]  pending;
    logic [TO_W-1:0]   to_cnt;
    logic [1:0]        frame_cnt;
    logic              vs_edge;
    logic              hs_edge;
    logic              to_expire;
    logic              cfg_apply;

    mist_sync_edge #(.ACTIVE_LOW(VS_ACTIVE_LOW)) u_vs_edge (
        .clk   (clk_sys),
        .rst_n (reset_n),
        .sync  (VSync),
        .lead  (vs_edge)
    );

    mist_sync_edge #(.ACTIVE_LOW(VS_ACTIVE_LOW)) u_hs_edge (
        .clk   (clk_sys),
        .rst_n (reset_n),
        .sync  (HSync),
        .lead  (hs_edge)
    );

    // Expiry is the cycle whose decrement would reach zero, so the counter never wraps.
    assign to_expire = (to_cnt <= TO_W'(1));
    assign cfg_apply = (state == WAIT_VS) && (vs_edge || to_expire);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            pending      <= '0;
            cfg_applied  <= RESET_CFG;
            blank        <= 1'b0;
            busy         <= 1'b0;
            cfg_ready    <= 1'b1;
            timeout_flag <= 1'b0;
            to_cnt       <= '0;
            frame_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid && cfg_ready) begin
                        pending      <= cfg_data;
                        timeout_flag <= 1'b0;
                        if (cfg_data != cfg_applied) begin
                            state     <= WAIT_VS;
                            cfg_ready <= 1'b0;
                            busy      <= 1'b1;
                            to_cnt    <= TO_LOAD;
                        end
                    end
                end

                WAIT_VS: begin
                    if (vs_edge || to_expire) begin
                        cfg_applied  <= pending;
                        timeout_flag <= ~vs_edge;
                        if (BLANK_FRAMES == 0) begin
                            state     <= IDLE;
                            cfg_ready <= 1'b1;
                            busy      <= 1'b0;
                            to_cnt    <= '0;
                        end else begin
                            state     <= BLANK;
                            blank     <= 1'b1;
                            frame_cnt <= FRAME_LOAD;
                            to_cnt    <= TO_LOAD;
                        end
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end

                BLANK: begin
                    if (vs_edge) begin
                        if (frame_cnt <= 2'd1) begin
                            state     <= IDLE;
                            blank     <= 1'b0;
                            cfg_ready <= 1'b1;
                            busy      <= 1'b0;
                            to_cnt    <= '0;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt - 1'b1;
                            to_cnt    <= TO_LOAD;
                        end
                    end else if (to_expire) begin
                        state        <= IDLE;
                        blank        <= 1'b0;
                        cfg_ready    <= 1'b1;
                        busy         <= 1'b0;
                        timeout_flag <= 1'b1;
                        to_cnt       <= '0;
                        frame_cnt    <= '0;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    blank     <= 1'b0;
                    cfg_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef MIST_VIDEO_LINECNT_EN
    logic [LINE_CNT_W-1:0] line_cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            line_cnt        <= '0;
            lines_per_frame <= '0;
            frame_stable    <= 1'b0;
        end else begin
            if (vs_edge) begin
                lines_per_frame <= line_cnt;
                line_cnt        <= '0;
                frame_stable    <= (line_cnt == lines_per_frame) && (line_cnt != '0);
            end else if (hs_edge && (line_cnt != '1)) begin
                line_cnt <= line_cnt + 1'b1;
            end
            // A freshly applied config invalidates any stability claim.
            if (cfg_apply) begin
                frame_stable <= 1'b0;
            end
        end
    end
`else
    logic unused_linecnt;

    assign unused_linecnt  = ^{hs_edge, cfg_apply};
    assign lines_per_frame = '0;
    assign frame_stable    = 1'b0;
`endif

endmodule

// File: tb/tb_mist_video_cfg_sched.sv
// Self-checking bench for mist_video_cfg_sched; honours MIST_VIDEO_LINECNT_EN when defined.
module tb_mist_video_cfg_sched;

    localparam int unsigned TO_CYC = 1000;

    logic       clk_sys;
    logic       reset_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [8:0] cfg_data;
    logic       HSync;
    logic       VSync;
    logic [8:0] cfg_applied;
    logic       blank;
    logic       busy;
    logic       timeout_flag;
    logic [9:0] lines_per_frame;
    logic       frame_stable;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] model_cfg;

    mist_video_cfg_sched #(
        .CFG_W         (9),
        .RESET_CFG     (9'h000),
        .BLANK_FRAMES  (2),
        .TIMEOUT_CYC   (TO_CYC),
        .TO_W          (21),
        .VS_ACTIVE_LOW (1'b1)
    ) dut (
        .clk_sys         (clk_sys),
        .reset_n         (reset_n),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_data        (cfg_data),
        .HSync           (HSync),
        .VSync           (VSync),
        .cfg_applied     (cfg_applied),
        .blank           (blank),
        .busy            (busy),
        .timeout_flag    (timeout_flag),
        .lines_per_frame (lines_per_frame),
        .frame_stable    (frame_stable)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Drive VSync to its active level; returns just after the edge has been registered.
    task automatic vs_fall();
        VSync = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic vs_release();
        cycles(3);
        VSync = 1'b1;
        cycles(2);
    endtask

    task automatic rand_cfg(output logic [8:0] c, input logic [8:0] avoid);
        c = 9'($urandom_range(0, 511));
        if (c == avoid) c = c ^ 9'h100;
    endtask

    task automatic accept(input logic [8:0] c);
        cfg_data  = c;
        cfg_valid = 1'b1;
        @(negedge clk_sys);
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cfg_valid = 1'b0; cfg_data = '0; HSync = 1'b1; VSync = 1'b1;
        cycles(3);
        n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
        n_checks++; if (cfg_applied !== 9'h000) begin n_fail++; $display("FAIL reset_cfg: got %h want 000", cfg_applied); end
        n_checks++; if ({blank, busy, timeout_flag, frame_stable} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_flags: blank/busy/tflag/stable=%b want 0000", {blank, busy, timeout_flag, frame_stable}); end
        n_checks++; if (lines_per_frame !== 10'd0) begin n_fail++; $display("FAIL reset_lpf: got %0d want 0", lines_per_frame); end
        reset_n = 1'b1;
        cycles(2);
        model_cfg = 9'h000;
        n_checks++; if (cfg_ready !== 1'b1 || busy !== 1'b0) begin n_fail++;
            $display("FAIL post_reset_idle: ready=%b busy=%b want 1/0", cfg_ready, busy); end
    endtask

    task automatic test_basic();
        accept(9'h008);
        n_checks++; if (cfg_ready !== 1'b0 || busy !== 1'b1) begin n_fail++;
            $display("FAIL basic_accept: ready=%b busy=%b want 0/1", cfg_ready, busy); end
        cycles(99);
        n_checks++; if (cfg_applied !== model_cfg || blank !== 1'b0) begin n_fail++;
            $display("FAIL basic_pre_vs: cfg=%h blank=%b want %h/0", cfg_applied, blank, model_cfg); end
        vs_fall();
        model_cfg = 9'h008;
        n_checks++; if (cfg_applied !== 9'h008 || blank !== 1'b1) begin n_fail++;
            $display("FAIL basic_apply: cfg=%h blank=%b want 008/1", cfg_applied, blank); end
        vs_release(); cycles(50);
        vs_fall();
        n_checks++; if (blank !== 1'b1 || cfg_ready !== 1'b0) begin n_fail++;
            $display("FAIL basic_blank1: blank=%b ready=%b want 1/0", blank, cfg_ready); end
        vs_release(); cycles(50);
        vs_fall();
        n_checks++; if (blank !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0 || timeout_flag !== 1'b0) begin n_fail++;
            $display("FAIL basic_done: blank=%b ready=%b busy=%b tflag=%b want 0/1/0/0", blank, cfg_ready, busy, timeout_flag); end
        vs_release();
    endtask

    task automatic test_noop();
        cfg_data  = model_cfg;
        cfg_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_sys);
            if (i == 3) VSync = 1'b0;
            n_checks++; if (cfg_ready !== 1'b1 || blank !== 1'b0 || busy !== 1'b0) begin n_fail++;
                $display("FAIL noop_cycle%0d: ready=%b blank=%b busy=%b want 1/0/0", i, cfg_ready, blank, busy); end
        end
        cfg_valid = 1'b0;
        vs_release();
        n_checks++; if (cfg_applied !== model_cfg) begin n_fail++;
            $display("FAIL noop_cfg: got %h want %h", cfg_applied, model_cfg); end
    endtask

    task automatic test_random_changes();
        logic [8:0] c;
        int gap;
        for (int it = 0; it < 6; it++) begin
            rand_cfg(c, model_cfg);
            gap = $urandom_range(10, 400);
            accept(c);
            cycles(gap - 1);
            n_checks++; if (cfg_applied !== model_cfg) begin n_fail++;
                $display("FAIL rand%0d_hold: got %h want %h", it, cfg_applied, model_cfg); end
            vs_fall();
            model_cfg = c;
            n_checks++; if (cfg_applied !== c || blank !== 1'b1) begin n_fail++;
                $display("FAIL rand%0d_apply: cfg=%h blank=%b want %h/1", it, cfg_applied, blank, c); end
            for (int f = 0; f < 2; f++) begin
                vs_release();
                cycles($urandom_range(20, 300));
                vs_fall();
            end
            n_checks++; if (blank !== 1'b0 || cfg_ready !== 1'b1) begin n_fail++;
                $display("FAIL rand%0d_end: blank=%b ready=%b want 0/1", it, blank, cfg_ready); end
            vs_release();
        end
    endtask

    task automatic test_timeout();
        logic [8:0] c;
        rand_cfg(c, model_cfg);
        accept(c);
        cycles(TO_CYC - 1);
        n_checks++; if (cfg_applied !== model_cfg || timeout_flag !== 1'b0) begin n_fail++;
            $display("FAIL to_before: cfg=%h tflag=%b want %h/0", cfg_applied, timeout_flag, model_cfg); end
        cycles(1);
        model_cfg = c;
        n_checks++; if (cfg_applied !== c || timeout_flag !== 1'b1 || blank !== 1'b1) begin n_fail++;
            $display("FAIL to_apply: cfg=%h tflag=%b blank=%b want %h/1/1", cfg_applied, timeout_flag, blank, c); end
        cycles(TO_CYC - 1);
        n_checks++; if (blank !== 1'b1) begin n_fail++; $display("FAIL to_blank_hold: blank=%b want 1", blank); end
        cycles(1);
        n_checks++; if (blank !== 1'b0 || cfg_ready !== 1'b1 || timeout_flag !== 1'b1) begin n_fail++;
            $display("FAIL to_blank_end: blank=%b ready=%b tflag=%b want 0/1/1", blank, cfg_ready, timeout_flag); end
        rand_cfg(c, model_cfg);
        accept(c);
        n_checks++; if (timeout_flag !== 1'b0) begin n_fail++; $display("FAIL to_clear: tflag=%b want 0", timeout_flag); end
        cycles(20);
        for (int f = 0; f < 3; f++) begin
            vs_fall();
            vs_release();
            cycles(30);
        end
        model_cfg = c;
        n_checks++; if (cfg_applied !== c || timeout_flag !== 1'b0 || cfg_ready !== 1'b1) begin n_fail++;
            $display("FAIL to_next: cfg=%h tflag=%b ready=%b want %h/0/1", cfg_applied, timeout_flag, cfg_ready, c); end
    endtask

    task automatic test_hold_during_blank();
        logic [8:0] c1, c2;
        rand_cfg(c1, model_cfg);
        rand_cfg(c2, c1);
        accept(c1);
        cycles(30);
        vs_fall();
        model_cfg = c1;
        vs_release();
        cfg_data  = c2;
        cfg_valid = 1'b1;
        cycles(40);
        n_checks++; if (cfg_ready !== 1'b0 || cfg_applied !== c1) begin n_fail++;
            $display("FAIL hold_blank: ready=%b cfg=%h want 0/%h", cfg_ready, cfg_applied, c1); end
        vs_fall();
        vs_release();
        cycles(40);
        vs_fall();
        n_checks++; if (cfg_ready !== 1'b1 || blank !== 1'b0 || cfg_applied !== c1) begin n_fail++;
            $display("FAIL hold_idle: ready=%b blank=%b cfg=%h want 1/0/%h", cfg_ready, blank, cfg_applied, c1); end
        @(negedge clk_sys);
        cfg_valid = 1'b0;
        n_checks++; if (cfg_ready !== 1'b0 || busy !== 1'b1) begin n_fail++;
            $display("FAIL hold_accept: ready=%b busy=%b want 0/1", cfg_ready, busy); end
        vs_release();
        cycles(25);
        n_checks++; if (cfg_applied !== c1) begin n_fail++;
            $display("FAIL hold_wait: cfg=%h want %h", cfg_applied, c1); end
        vs_fall();
        model_cfg = c2;
        n_checks++; if (cfg_applied !== c2 || blank !== 1'b1) begin n_fail++;
            $display("FAIL hold_apply: cfg=%h blank=%b want %h/1", cfg_applied, blank, c2); end
        for (int f = 0; f < 2; f++) begin
            vs_release();
            cycles(30);
            vs_fall();
        end
        vs_release();
    endtask

    task automatic test_reset_mid_blank();
        logic [8:0] c;
        rand_cfg(c, model_cfg);
        accept(c);
        cycles(20);
        vs_fall();
        vs_release();
        cycles(10);
        n_checks++; if (blank !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: blank=%b want 1", blank); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (cfg_applied !== 9'h000 || blank !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin n_fail++;
            $display("FAIL rstmid_async: cfg=%h blank=%b ready=%b busy=%b want 000/0/1/0", cfg_applied, blank, cfg_ready, busy); end
        @(negedge clk_sys);
        reset_n = 1'b1;
        model_cfg = 9'h000;
        cycles(2);
    endtask

    task automatic run_lines(input int lines);
        for (int l = 0; l < lines; l++) begin
            HSync = 1'b0;
            @(negedge clk_sys);
            HSync = 1'b1;
            cycles(2);
        end
    endtask

    task automatic test_linecnt();
`ifdef MIST_VIDEO_LINECNT_EN
        int frames [6];
        int model_lpf;
        logic exp_stable;
        frames = '{262, 262, 262, 263, 263, 0};
        frames[5] = $urandom_range(100, 300);
        model_lpf = 0;
        for (int f = 0; f < 6; f++) begin
            run_lines(frames[f]);
            vs_fall();
            exp_stable = (frames[f] == model_lpf) && (frames[f] != 0);
            model_lpf  = frames[f];
            n_checks++; if (lines_per_frame !== 10'(model_lpf) || frame_stable !== exp_stable) begin n_fail++;
                $display("FAIL linecnt_f%0d: lpf=%0d stable=%b want %0d/%b", f, lines_per_frame, frame_stable, model_lpf, exp_stable); end
            vs_release();
        end
`else
        run_lines(20);
        vs_fall();
        n_checks++; if (lines_per_frame !== 10'd0 || frame_stable !== 1'b0) begin n_fail++;
            $display("FAIL linecnt_off: lpf=%0d stable=%b want 0/0", lines_per_frame, frame_stable); end
        vs_release();
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_noop();
        test_random_changes();
        test_timeout();
        test_hold_during_blank();
        test_reset_mid_blank();
        test_linecnt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
